// File: rtl/clk_seq_ctrl_if.sv
// Width-change handshake and clock-control bundle for clk_seq_ctrl.
// master: requester/observer side; slave: the sequencer.
interface clk_seq_ctrl_if;
  logic       Width_Req;
  logic [5:0] Req_Width;
  logic [5:0] DataBusWidth;
  logic       Div_Rst_n;
  logic       Clk_En;
  logic       Clk_Ready;
  logic       Req_Ack;
  logic       Req_Err;
  logic       PhyStatus;

  modport master (
    output Width_Req, Req_Width,
    input  DataBusWidth, Div_Rst_n, Clk_En,
    input  Clk_Ready, Req_Ack, Req_Err, PhyStatus
  );

  modport slave (
    input  Width_Req, Req_Width,
    output DataBusWidth, Div_Rst_n, Clk_En,
    output Clk_Ready, Req_Ack, Req_Err, PhyStatus
  );
endinterface

// File: rtl/clk_seq_ctrl.sv
// PHY clock sequencer: PLL settle, divider reset, settle, width changes.
// Ports: Ref_Clk, Rst (sync, active-high), [Pll_Locked], bus (slave).
// Optional macro CLK_SEQ_PLL_LOCK_EN adds Pll_Locked lock supervision.
module clk_seq_ctrl #(
  parameter int unsigned PLL_LOCK_CYCLES = 200,
  parameter int unsigned DIV_RST_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned GATE_CYCLES     = 2
) (
  input logic           Ref_Clk,
  input logic           Rst,
`ifdef CLK_SEQ_PLL_LOCK_EN
  input logic           Pll_Locked,
`endif
  clk_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    PLL_WAIT,
    DIV_RST,
    SETTLE,
    READY,
    GATE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lim;
  logic        tc;
  logic        retry;
  logic        lost;
  logic        legal;
  logic        req;
  logic [5:0]  rw;

  logic [5:0]  width_q, width_d;
  logic [5:0]  new_w_q, new_w_d;
  logic        pend_q, pend_d;
  logic        drst_n_q, drst_n_d;
  logic        clk_en_q, clk_en_d;
  logic        rdy_q, rdy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        phy_q, phy_d;

  assign req   = bus.Width_Req;
  assign rw    = bus.Req_Width;
  assign legal = (rw == 6'd8) || (rw == 6'd16) || (rw == 6'd32);

  always_comb begin
    lim = 16'(PLL_LOCK_CYCLES - 1);
    unique case (state_q)
      DIV_RST: lim = 16'(DIV_RST_CYCLES - 1);
      SETTLE:  lim = 16'(SETTLE_CYCLES - 1);
      GATE:    lim = 16'(GATE_CYCLES - 1);
      default: lim = 16'(PLL_LOCK_CYCLES - 1);
    endcase
  end

  assign tc = (cnt_q == lim);

`ifdef CLK_SEQ_PLL_LOCK_EN
  // Run length of consecutive Pll_Locked=1 samples, saturating at 3.
  logic [1:0] lock_q, lock_d;
  logic       locked4;

  assign locked4 = Pll_Locked && (lock_q == 2'd3);
  assign lost    = !Pll_Locked &&
                   ((state_q == READY) || (state_q == GATE));

  always_comb begin
    lock_d = 2'd0;
    if ((state_q == PLL_WAIT) && Pll_Locked)
      lock_d = (lock_q == 2'd3) ? lock_q : lock_q + 2'd1;
  end

  always_ff @(posedge Ref_Clk) begin
    if (Rst) lock_q <= 2'd0;
    else     lock_q <= lock_d;
  end
`else
  assign lost = 1'b0;
`endif

  // State register.
  always_ff @(posedge Ref_Clk) begin
    if (Rst) begin
      state_q  <= PLL_WAIT;
      cnt_q    <= '0;
      width_q  <= 6'd8;
      new_w_q  <= 6'd8;
      pend_q   <= 1'b0;
      drst_n_q <= 1'b0;
      clk_en_q <= 1'b0;
      rdy_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      phy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      new_w_q  <= new_w_d;
      pend_q   <= pend_d;
      drst_n_q <= drst_n_d;
      clk_en_q <= clk_en_d;
      rdy_q    <= rdy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      phy_q    <= phy_d;
    end
  end

  // Next state and shared counter.
  always_comb begin
    state_d = state_q;
    retry   = 1'b0;
    unique case (state_q)
      PLL_WAIT: begin
`ifdef CLK_SEQ_PLL_LOCK_EN
        if (locked4) state_d = DIV_RST;
        else if (tc) retry = 1'b1;
`else
        if (tc) state_d = DIV_RST;
`endif
      end
      DIV_RST: if (tc) state_d = SETTLE;
      SETTLE:  if (tc) state_d = READY;
      READY: begin
        if (req && legal && (rw != width_q))
          state_d = GATE;
      end
      GATE:    if (tc) state_d = DIV_RST;
      default: state_d = PLL_WAIT;
    endcase
    if (lost) state_d = PLL_WAIT;
    if ((state_d != state_q) || retry || (state_q == READY))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;
  end

  // Registered output next-values.
  always_comb begin
    width_d  = width_q;
    new_w_d  = new_w_q;
    pend_d   = pend_q;
    drst_n_d = drst_n_q;
    clk_en_d = clk_en_q;
    rdy_d    = rdy_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    phy_d    = 1'b0;
    unique case (state_q)
      DIV_RST: if (tc) drst_n_d = 1'b1;
      SETTLE: begin
        if (tc) begin
          clk_en_d = 1'b1;
          rdy_d    = 1'b1;
          phy_d    = 1'b1;
          ack_d    = pend_q;
          pend_d   = 1'b0;
        end
      end
      READY: begin
        if (req) begin
          unique case (1'b1)
            !legal: err_d = 1'b1;
            legal && (rw == width_q): ack_d = 1'b1;
            legal && (rw != width_q): begin
              rdy_d    = 1'b0;
              clk_en_d = 1'b0;
              new_w_d  = rw;
              pend_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      GATE: begin
        if (tc) begin
          width_d  = new_w_q;
          drst_n_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Requests outside READY are refused; a completing ack
    // takes the slot so ack and err never coincide.
    if (req && (state_q != READY) && !ack_d)
      err_d = 1'b1;
    if (retry)
      err_d = 1'b1;
    if (lost) begin
      width_d  = width_q;
      rdy_d    = 1'b0;
      clk_en_d = 1'b0;
      drst_n_d = 1'b0;
      pend_d   = 1'b0;
      ack_d    = 1'b0;
      err_d    = req;
    end
  end

  assign bus.DataBusWidth = width_q;
  assign bus.Div_Rst_n    = drst_n_q;
  assign bus.Clk_En       = clk_en_q;
  assign bus.Clk_Ready    = rdy_q;
  assign bus.Req_Ack      = ack_q;
  assign bus.Req_Err      = err_q;
  assign bus.PhyStatus    = phy_q;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// Directed bench for clk_seq_ctrl at default parameters.
// Edge e counts rising edges since the last reset release.
module tb_clk_seq_ctrl;

  logic Ref_Clk = 1'b0;
  logic Rst     = 1'b1;
`ifdef CLK_SEQ_PLL_LOCK_EN
  logic Pll_Locked = 1'b1;
`endif

  clk_seq_ctrl_if bus();

  clk_seq_ctrl dut (
    .Ref_Clk    (Ref_Clk),
    .Rst        (Rst),
`ifdef CLK_SEQ_PLL_LOCK_EN
    .Pll_Locked (Pll_Locked),
`endif
    .bus        (bus)
  );

  always #5 Ref_Clk = ~Ref_Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               tag, got, exp, e);
    end
  endtask

  task automatic step();
    @(posedge Ref_Clk);
    #1;
    e++;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_width"}, bus.DataBusWidth, 8);
    check({tag, "_drst"}, bus.Div_Rst_n, 0);
    check({tag, "_clken"}, bus.Clk_En, 0);
    check({tag, "_rdy"}, bus.Clk_Ready, 0);
    check({tag, "_ack"}, bus.Req_Ack, 0);
    check({tag, "_err"}, bus.Req_Err, 0);
    check({tag, "_phy"}, bus.PhyStatus, 0);
  endtask

  // Runs from reset release to edge 230; probes a refused request
  // during the PLL wait (raised after edge 49, refused at edge 50).
  task automatic power_up(input string tag);
    int dr_at  = -1;
    int rdy_at = -1;
    int en_at  = -1;
    int phy_at = -1;
    int acks   = 0;
    e = 0;
    for (int i = 0; i < 230; i++) begin
      step();
      if (dr_at < 0 && bus.Div_Rst_n) dr_at = e;
      if (rdy_at < 0 && bus.Clk_Ready) rdy_at = e;
      if (en_at < 0 && bus.Clk_En) en_at = e;
      if (phy_at < 0 && bus.PhyStatus) phy_at = e;
      acks += int'(bus.Req_Ack);
      if (e == 50) begin
        check({tag, "_pll_req_err"}, bus.Req_Err, 1);
        bus.Width_Req = 1'b0;
      end
      if (e == 49) begin
        bus.Width_Req = 1'b1;
        bus.Req_Width = 6'd16;
      end
    end
    check({tag, "_drst_rise"}, dr_at, 204);
    check({tag, "_rdy_rise"}, rdy_at, 220);
    check({tag, "_en_rise"}, en_at, 220);
    check({tag, "_phy_at"}, phy_at, 220);
    check({tag, "_acks"}, acks, 0);
    check({tag, "_width"}, bus.DataBusWidth, 8);
    check({tag, "_phy_low"}, bus.PhyStatus, 0);
  endtask

  task automatic request(input logic [5:0] w);
    bus.Width_Req = 1'b1;
    bus.Req_Width = w;
    step();
    bus.Width_Req = 1'b0;
  endtask

  initial begin
    int n;
    int acks;
    int phys;
    int rdy_at;
    bus.Width_Req = 1'b0;
    bus.Req_Width = 6'd8;

    repeat (3) step();
    check_reset("rst");
    Rst = 1'b0;

    power_up("pu1");

    // Same width: immediate ack, clocks untouched.
    request(6'd8);
    check("same_ack", bus.Req_Ack, 1);
    check("same_err", bus.Req_Err, 0);
    check("same_rdy", bus.Clk_Ready, 1);
    check("same_phy", bus.PhyStatus, 0);
    check("same_drst", bus.Div_Rst_n, 1);
    step();
    check("same_ack_end", bus.Req_Ack, 0);

    // Illegal width: error only.
    request(6'd12);
    check("bad_err", bus.Req_Err, 1);
    check("bad_ack", bus.Req_Ack, 0);
    check("bad_width", bus.DataBusWidth, 8);
    check("bad_rdy", bus.Clk_Ready, 1);
    step();
    check("bad_err_end", bus.Req_Err, 0);

    // Change to 16 with a refused 32 request mid-change.
    n = e;
    request(6'd16);
    check("chg_rdy_fall", bus.Clk_Ready, 0);
    check("chg_en_fall", bus.Clk_En, 0);
    check("chg_width_n1", bus.DataBusWidth, 8);
    step();
    check("chg_width_n2", bus.DataBusWidth, 8);
    check("chg_drst_n2", bus.Div_Rst_n, 1);
    request(6'd32);
    check("chg_width_n3", bus.DataBusWidth, 16);
    check("chg_drst_n3", bus.Div_Rst_n, 0);
    check("chg_busy_err", bus.Req_Err, 1);
    acks = 0;
    phys = 0;
    rdy_at = -1;
    while (e < n + 30) begin
      step();
      if (e == n + 6) check("chg_drst_n6", bus.Div_Rst_n, 0);
      if (e == n + 7) check("chg_drst_n7", bus.Div_Rst_n, 1);
      if (rdy_at < 0 && bus.Clk_Ready) rdy_at = e - n;
      acks += int'(bus.Req_Ack);
      phys += int'(bus.PhyStatus);
      if (e == n + 23) begin
        check("chg_ack_n23", bus.Req_Ack, 1);
        check("chg_phy_n23", bus.PhyStatus, 1);
      end
    end
    check("chg_rdy_at", rdy_at, 23);
    check("chg_acks", acks, 1);
    check("chg_phys", phys, 1);
    check("chg_width_final", bus.DataBusWidth, 16);
    check("chg_en_final", bus.Clk_En, 1);

    // Change to 32 aborted by reset after edge N+10.
    n = e;
    request(6'd32);
    while (e < n + 10) step();
    check("abort_width_32", bus.DataBusWidth, 32);
    Rst = 1'b1;
    step();
    check_reset("abort");
    Rst = 1'b0;

    power_up("pu2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
